// File: rtl/ptp_pkg.sv
// Shared constants, enums and chunk-placement helpers for the inbound
// parallel-to-parallel deserialiser.
package ptp_pkg;

    localparam int FRAME_W         = 160;
    localparam int BYTES_PER_FRAME = 20;
    localparam int BITS_PER_FRAME  = 160;

    typedef enum logic {PTP_BYTE, PTP_BIT} ptp_mode_e;

    typedef enum logic {IDLE, FILL} ptp_deser_state_e;

    function automatic logic [7:0] last_index(input ptp_mode_e mode);
        return (mode == PTP_BIT) ? 8'(BITS_PER_FRAME - 1) : 8'(BYTES_PER_FRAME - 1);
    endfunction

    // MSB-first placement: chunk k lands at the top of the frame minus its offset.
    function automatic logic [7:0] chunk_msb(input ptp_mode_e mode, input logic [7:0] ptr);
        return (mode == PTP_BIT) ? 8'(FRAME_W - 1) - ptr
                                 : 8'(FRAME_W - 1) - {ptr[4:0], 3'b000};
    endfunction

endpackage

// File: rtl/ptp_deser_sync_rise.sv
// Multi-flop synchroniser for an asynchronous pin followed by a
// rising-edge detector producing a single-cycle pulse.
module sync_rise #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic din,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/ptp_deser.sv
// Rebuilds a 160-bit frame from strobed byte or bit chunks and presents it
// as five words with a valid/ack handshake and a sticky overrun flag.
module ptp_deser #(
    parameter int NUM_WORDS   = 5,
    parameter int WORD_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              strobe_i,
    input  logic              serialise_i,
    input  logic [7:0]        value_i,
    input  logic              ack_i,
    output logic [WORD_W-1:0] value_a_o,
    output logic [WORD_W-1:0] value_b_o,
    output logic [WORD_W-1:0] value_c_o,
    output logic [WORD_W-1:0] value_d_o,
    output logic [WORD_W-1:0] value_e_o,
    output logic              frame_valid_o,
    output logic              busy_o,
    output logic              overrun_o
);

    import ptp_pkg::*;

    localparam int FRAME_BITS = NUM_WORDS * WORD_W;

    ptp_deser_state_e        state_q, state_d;
    ptp_mode_e               mode_q, cur_mode;
    logic [7:0]              ptr_q;
    logic [7:0]              msb;
    logic [FRAME_BITS-1:0]   shadow_q, merged, frame_q;
    logic                    frame_valid_q, overrun_q;
    logic                    take, load_first, store, complete;

    sync_rise #(.STAGES(SYNC_STAGES)) u_strobe_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .din     (strobe_i),
        .rise    (take)
    );

    // The mode pin only matters for the first chunk; afterwards the latched mode rules.
    assign cur_mode = (state_q == IDLE) ? ptp_mode_e'(serialise_i) : mode_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (take) state_d = FILL;
            FILL: if (take && ptr_q == last_index(mode_q)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_first = 1'b0;
        store      = 1'b0;
        complete   = 1'b0;
        case (state_q)
            IDLE: load_first = take;
            FILL: begin
                if (take) begin
                    if (ptr_q == last_index(mode_q)) complete = 1'b1;
                    else                             store    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Start each frame from a clean shadow so stale bits never leak through.
    always_comb begin
        merged = (state_q == IDLE) ? '0 : shadow_q;
        msb    = chunk_msb(cur_mode, ptr_q);
        if (cur_mode == PTP_BIT) merged[msb]      = value_i[0];
        else                     merged[msb -: 8] = value_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mode_q        <= PTP_BYTE;
            ptr_q         <= '0;
            shadow_q      <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            if (load_first) mode_q <= cur_mode;
            if (load_first || store) begin
                shadow_q <= merged;
                ptr_q    <= ptr_q + 8'd1;
            end
            if (complete) begin
                ptr_q   <= '0;
                frame_q <= merged;
            end
            if (complete)   frame_valid_q <= 1'b1;
            else if (ack_i) frame_valid_q <= 1'b0;
            if (complete && frame_valid_q && !ack_i) overrun_q <= 1'b1;
        end
    end

    assign value_a_o     = frame_q[FRAME_BITS-1 -: WORD_W];
    assign value_b_o     = frame_q[FRAME_BITS-1-WORD_W -: WORD_W];
    assign value_c_o     = frame_q[FRAME_BITS-1-2*WORD_W -: WORD_W];
    assign value_d_o     = frame_q[FRAME_BITS-1-3*WORD_W -: WORD_W];
    assign value_e_o     = frame_q[WORD_W-1:0];
    assign frame_valid_o = frame_valid_q;
    assign busy_o        = (ptr_q != 8'd0);
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_ptp_deser.sv
// Scenario bench for ptp_deser: frames are modelled as MSB-first shifts of
// the chunks sent and compared against the five output words.
module tb_ptp_deser;

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b1;
    logic         strobe_i = 1'b0;
    logic         serialise_i = 1'b0;
    logic [7:0]   value_i = 8'd0;
    logic         ack_i = 1'b0;
    logic [31:0]  value_a_o, value_b_o, value_c_o, value_d_o, value_e_o;
    logic         frame_valid_o, busy_o, overrun_o;
    logic [159:0] dut_frame;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    assign dut_frame = {value_a_o, value_b_o, value_c_o, value_d_o, value_e_o};

    ptp_deser #(.NUM_WORDS(5), .WORD_W(32), .SYNC_STAGES(2)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .strobe_i      (strobe_i),
        .serialise_i   (serialise_i),
        .value_i       (value_i),
        .ack_i         (ack_i),
        .value_a_o     (value_a_o),
        .value_b_o     (value_b_o),
        .value_c_o     (value_c_o),
        .value_d_o     (value_d_o),
        .value_e_o     (value_e_o),
        .frame_valid_o (frame_valid_o),
        .busy_o        (busy_o),
        .overrun_o     (overrun_o)
    );

    // Strobe high for three periods then low for three, data held throughout.
    task automatic send_chunk(input logic [7:0] v);
        @(negedge clk_i);
        value_i  = v;
        strobe_i = 1'b1;
        repeat (3) @(negedge clk_i);
        strobe_i = 1'b0;
        repeat (3) @(negedge clk_i);
    endtask

    task automatic do_ack;
        @(negedge clk_i);
        ack_i = 1'b1;
        @(negedge clk_i);
        ack_i = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        checks++; if (dut_frame !== 160'd0) begin errors++; $display("[TB] FAIL reset_frame: got %h, expected 0", dut_frame); end
        checks++; if (frame_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b, expected 0", frame_valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b, expected 0", overrun_o); end
    endtask

    task automatic test_byte_frame;
        logic [159:0] exp;
        exp = '0;
        serialise_i = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            send_chunk(8'(k));
            exp = {exp[151:0], 8'(k)};
        end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL byte_busy_mid: got %b, expected 1", busy_o); end
        exp = {exp[151:0], 8'd20};
        @(negedge clk_i);
        value_i  = 8'd20;
        strobe_i = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk_i);
            #1;
            checks++;
            if (frame_valid_o !== logic'(c == 3)) begin
                errors++;
                $display("[TB] FAIL byte_latency_edge%0d: got %b, expected %b", c, frame_valid_o, logic'(c == 3));
            end
        end
        @(negedge clk_i);
        strobe_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++; if (dut_frame !== exp) begin errors++; $display("[TB] FAIL byte_frame: got %h, expected %h", dut_frame, exp); end
        checks++; if (value_a_o !== 32'h01020304) begin errors++; $display("[TB] FAIL byte_word_a: got %h, expected 01020304", value_a_o); end
        checks++; if (value_e_o !== 32'h11121314) begin errors++; $display("[TB] FAIL byte_word_e: got %h, expected 11121314", value_e_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL byte_busy_end: got %b, expected 0", busy_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("[TB] FAIL byte_overrun: got %b, expected 0", overrun_o); end
        do_ack();
        checks++; if (frame_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL byte_ack: got %b, expected 0", frame_valid_o); end
    endtask

    task automatic test_serial_frame;
        logic [31:0]  words [5];
        logic [159:0] exp;
        logic         bit_v;
        words[0] = 32'hDEADBEEF;
        words[1] = 32'h00000000;
        words[2] = 32'hFFFFFFFF;
        words[3] = 32'h80000001;
        words[4] = 32'h12345678;
        exp = '0;
        serialise_i = 1'b1;
        for (int w = 0; w < 5; w++) begin
            for (int b = 31; b >= 0; b--) begin
                bit_v = words[w][b];
                send_chunk({7'h7F, bit_v});
                exp = {exp[158:0], bit_v};
            end
        end
        serialise_i = 1'b0;
        checks++; if (dut_frame !== exp) begin errors++; $display("[TB] FAIL serial_frame: got %h, expected %h", dut_frame, exp); end
        checks++; if (value_a_o !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL serial_word_a: got %h, expected deadbeef", value_a_o); end
        checks++; if (value_d_o !== 32'h80000001) begin errors++; $display("[TB] FAIL serial_word_d: got %h, expected 80000001", value_d_o); end
        checks++; if (frame_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL serial_valid: got %b, expected 1", frame_valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL serial_busy: got %b, expected 0", busy_o); end
        do_ack();
    endtask

    task automatic test_overrun;
        logic [159:0] exp;
        logic [7:0]   b;
        serialise_i = 1'b0;
        for (int f = 0; f < 2; f++) begin
            exp = '0;
            for (int k = 0; k < 20; k++) begin
                b = 8'($urandom);
                send_chunk(b);
                exp = {exp[151:0], b};
            end
            if (f == 0) begin
                checks++; if (overrun_o !== 1'b0) begin errors++; $display("[TB] FAIL overrun_first: got %b, expected 0", overrun_o); end
            end
        end
        checks++; if (dut_frame !== exp) begin errors++; $display("[TB] FAIL overrun_frame: got %h, expected %h", dut_frame, exp); end
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("[TB] FAIL overrun_flag: got %b, expected 1", overrun_o); end
        checks++; if (frame_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL overrun_valid: got %b, expected 1", frame_valid_o); end
        do_ack();
        checks++; if (frame_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL overrun_ack_valid: got %b, expected 0", frame_valid_o); end
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("[TB] FAIL overrun_sticky: got %b, expected 1", overrun_o); end
    endtask

    task automatic test_reset_mid_frame;
        logic [159:0] exp;
        logic [7:0]   b;
        serialise_i = 1'b0;
        for (int k = 0; k < 7; k++) send_chunk(8'($urandom));
        checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL midreset_busy_before: got %b, expected 1", busy_o); end
        @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        checks++; if (dut_frame !== 160'd0) begin errors++; $display("[TB] FAIL midreset_frame: got %h, expected 0", dut_frame); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b, expected 0", busy_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("[TB] FAIL midreset_overrun: got %b, expected 0", overrun_o); end
        checks++; if (frame_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid: got %b, expected 0", frame_valid_o); end
        exp = '0;
        for (int k = 0; k < 20; k++) begin
            b = 8'($urandom);
            send_chunk(b);
            exp = {exp[151:0], b};
        end
        checks++; if (dut_frame !== exp) begin errors++; $display("[TB] FAIL midreset_next_frame: got %h, expected %h", dut_frame, exp); end
        checks++; if (frame_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL midreset_next_valid: got %b, expected 1", frame_valid_o); end
        do_ack();
    endtask

    task automatic test_mode_toggle_collision;
        logic [159:0] exp;
        logic [7:0]   b;
        exp = '0;
        serialise_i = 1'b0;
        for (int k = 0; k < 19; k++) begin
            if (k == 3) serialise_i = 1'b1;
            b = 8'($urandom);
            send_chunk(b);
            exp = {exp[151:0], b};
        end
        b = 8'($urandom);
        exp = {exp[151:0], b};
        @(negedge clk_i);
        value_i  = b;
        strobe_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        ack_i = 1'b1;
        @(negedge clk_i);
        ack_i    = 1'b0;
        strobe_i = 1'b0;
        checks++; if (frame_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL collide_valid: got %b, expected 1", frame_valid_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("[TB] FAIL collide_overrun: got %b, expected 0", overrun_o); end
        checks++; if (dut_frame !== exp) begin errors++; $display("[TB] FAIL toggle_frame: got %h, expected %h", dut_frame, exp); end
        repeat (3) @(negedge clk_i);
        checks++; if (frame_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL collide_valid_hold: got %b, expected 1", frame_valid_o); end
        serialise_i = 1'b0;
        do_ack();
        checks++; if (frame_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL collide_ack: got %b, expected 0", frame_valid_o); end
        do_ack();
        checks++; if (frame_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL idle_ack: got %b, expected 0", frame_valid_o); end
    endtask

    task automatic test_strobe_held;
        logic [159:0] exp;
        logic [7:0]   b;
        serialise_i = 1'b0;
        b = 8'($urandom);
        exp = {152'd0, b};
        @(negedge clk_i);
        value_i  = b;
        strobe_i = 1'b1;
        repeat (50) @(negedge clk_i);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL held_busy: got %b, expected 1", busy_o); end
        strobe_i = 1'b0;
        repeat (3) @(negedge clk_i);
        for (int k = 1; k < 20; k++) begin
            b = 8'($urandom);
            send_chunk(b);
            exp = {exp[151:0], b};
        end
        checks++; if (dut_frame !== exp) begin errors++; $display("[TB] FAIL held_frame: got %h, expected %h", dut_frame, exp); end
        checks++; if (frame_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL held_valid: got %b, expected 1", frame_valid_o); end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_byte_frame();
        test_serial_frame();
        test_overrun();
        test_reset_mid_frame();
        test_mode_toggle_collision();
        test_strobe_held();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
